// File: rtl/fp16_accumulator_ctrl.sv
// Sequencer that reduces a stream of fp16 elements into one sum per vector by
// driving an external fp16 adder through its start/clear/operand interface.
module fp16_accumulator_ctrl #(
  parameter int unsigned COUNT_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   reset_b,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [15:0]            in_data,
  input  logic                   in_last,
  output logic                   add_start,
  output logic [15:0]            add_a,
  output logic [15:0]            add_b,
  output logic                   add_clear,
  input  logic                   add_valid,
  input  logic [15:0]            add_result,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [15:0]            out_data,
  output logic [COUNT_WIDTH-1:0] out_count,
  output logic                   busy
);

  typedef enum logic [1:0] {
    StAccept,
    StAddStart,
    StAddWait,
    StOutput
  } state_e;

  localparam logic [COUNT_WIDTH-1:0] CntMax = '1;
  localparam logic [COUNT_WIDTH-1:0] CntOne = COUNT_WIDTH'(1);

  state_e                 state_q, state_d;
  logic [15:0]            acc_q, acc_d;
  logic [15:0]            opnd_q, opnd_d;
  logic                   last_q, last_d;
  logic                   first_q, first_d;
  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    last_d    = last_q;
    first_d   = first_q;
    cnt_d     = cnt_q;
    in_ready  = 1'b0;
    add_start = 1'b0;
    add_clear = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;

    unique case (state_q)
      StAccept: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          if (first_q) begin
            cnt_d   = CntOne;
            // The first element seeds the accumulator; no addition needed.
            acc_d   = in_data;
            first_d = 1'b0;
            if (in_last) begin
              state_d = StOutput;
            end
          end else begin
            cnt_d   = (cnt_q == CntMax) ? cnt_q : cnt_q + CntOne;
            opnd_d  = in_data;
            last_d  = in_last;
            state_d = StAddStart;
          end
        end
      end
      StAddStart: begin
        add_start = 1'b1;
        state_d   = StAddWait;
      end
      StAddWait: begin
        if (add_valid) begin
          acc_d     = add_result;
          add_clear = 1'b1;
          state_d   = last_q ? StOutput : StAccept;
        end
      end
      StOutput: begin
        out_valid = 1'b1;
        if (out_ready) begin
          first_d = 1'b1;
          state_d = StAccept;
        end
      end
      default: state_d = StAccept;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_b) begin
      state_q <= StAccept;
      acc_q   <= '0;
      opnd_q  <= '0;
      last_q  <= 1'b0;
      first_q <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      opnd_q  <= opnd_d;
      last_q  <= last_d;
      first_q <= first_d;
      cnt_q   <= cnt_d;
    end
  end

  assign add_a     = acc_q;
  assign add_b     = opnd_q;
  // Sum and count read as zero whenever no result is being offered.
  assign out_data  = out_valid ? acc_q : '0;
  assign out_count = out_valid ? cnt_q : '0;

endmodule
